// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: 2-FF sync, stable-level debounce and a
// hold FSM emitting registered press/release/long/repeat strobes per channel.
module btn_conditioner #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 20_000_000,
  parameter int unsigned LONG_CYCLES     = 40_000_000,
  parameter int unsigned REPEAT_CYCLES   = 5_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] btn_i,
  input  logic [CHANNELS-1:0] repeat_en_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] long_o,
  output logic [CHANNELS-1:0] repeat_o
);

  localparam int unsigned DW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HoldMax = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW      = $clog2(HoldMax) + 1;

  localparam logic [DW-1:0] DebLast    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LongLast   = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] RepeatLast = HW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHeld, StLong} hold_st_e;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic          sync1_q, sync2_q, raw;
    logic          level_q, level_d, rise, fall;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    hold_st_e      st_q, st_d;
    logic          press_q, press_d, release_q, release_d;
    logic          long_q, long_d, repeat_q, repeat_d;

    // Sync flops reset to the idle pin level so a held button reads as a new press.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync1_q <= ACTIVE_LOW;
        sync2_q <= ACTIVE_LOW;
      end else begin
        sync1_q <= btn_i[c];
        sync2_q <= sync1_q;
      end
    end

    assign raw = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
      level_d = level_q;
      dcnt_d  = dcnt_q;
      rise    = 1'b0;
      fall    = 1'b0;
      if (raw == level_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DebLast) begin
        level_d = ~level_q;
        dcnt_d  = '0;
        rise    = raw;
        fall    = ~raw;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end

    // The edge events come from the debounce next-state so strobes align with level_o.
    always_comb begin
      st_d      = st_q;
      hcnt_d    = hcnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      case (st_q)
        StIdle: begin
          if (rise) begin
            press_d = 1'b1;
            hcnt_d  = '0;
            st_d    = StHeld;
          end
        end
        StHeld: begin
          if (fall) begin
            release_d = 1'b1;
            hcnt_d    = '0;
            st_d      = StIdle;
          end else if (hcnt_q == LongLast) begin
            long_d = 1'b1;
            hcnt_d = '0;
            st_d   = StLong;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        StLong: begin
          if (fall) begin
            release_d = 1'b1;
            hcnt_d    = '0;
            st_d      = StIdle;
          end else if (!repeat_en_i[c]) begin
            hcnt_d = '0;
          end else if (hcnt_q == RepeatLast) begin
            repeat_d = 1'b1;
            hcnt_d   = '0;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        default: begin
          st_d   = StIdle;
          hcnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        level_q   <= 1'b0;
        dcnt_q    <= '0;
        st_q      <= StIdle;
        hcnt_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        level_q   <= level_d;
        dcnt_q    <= dcnt_d;
        st_q      <= st_d;
        hcnt_q    <= hcnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        repeat_q  <= repeat_d;
      end
    end

    assign level_o[c]   = level_q;
    assign press_o[c]   = press_q;
    assign release_o[c] = release_q;
    assign long_o[c]    = long_q;
    assign repeat_o[c]  = repeat_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: expected strobes are queued with their due
// cycle when stimulus is driven and compared against the DUT on every falling edge.
module tb_btn_conditioner;

  localparam int unsigned Ch = 2;

  localparam int KPress   = 0;
  localparam int KRelease = 1;
  localparam int KLong    = 2;
  localparam int KRepeat  = 3;

  typedef struct {
    int unsigned t;
    int          kind;
    int          ch;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [Ch-1:0] btn = '1;
  logic [Ch-1:0] repeat_en = '0;
  logic [Ch-1:0] level, press, rel, lng, rpt;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         q[$];
  logic [Ch-1:0] exp_level = '0;

  btn_conditioner #(
    .CHANNELS       (Ch),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .REPEAT_CYCLES  (3),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .btn_i      (btn),
    .repeat_en_i(repeat_en),
    .level_o    (level),
    .press_o    (press),
    .release_o  (rel),
    .long_o     (lng),
    .repeat_o   (rpt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void push(input int unsigned t, input int kind, input int ch);
    ev_t e;
    e.t    = t;
    e.kind = kind;
    e.ch   = ch;
    q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Outputs after edge N are compared against events due at cycle N.
  always @(negedge clk) begin
    logic [Ch-1:0] ep, er, el, erp;
    ep = '0; er = '0; el = '0; erp = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].t == cyc) begin
        case (q[i].kind)
          KPress:   ep[q[i].ch]  = 1'b1;
          KRelease: er[q[i].ch]  = 1'b1;
          KLong:    el[q[i].ch]  = 1'b1;
          default:  erp[q[i].ch] = 1'b1;
        endcase
        q.delete(i);
      end
    end
    if (rst) exp_level = '0;
    exp_level = (exp_level | ep) & ~er;
    check("press", 32'(press), 32'(ep));
    check("release", 32'(rel), 32'(er));
    check("long", 32'(lng), 32'(el));
    check("repeat", 32'(rpt), 32'(erp));
    check("level", 32'(level), 32'(exp_level));
  end

  initial begin
    int unsigned base;
    int unsigned rb;

    #2;
    check("reset_outputs", {22'd0, level, press, rel, lng, rpt}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(3);

    // Clean press, no repeat
    btn[0] = 1'b0; base = cyc;
    push(base + 6, KPress, 0);
    push(base + 16, KLong, 0);
    tick(30);
    btn[0] = 1'b1; rb = cyc;
    push(rb + 6, KRelease, 0);
    tick(12);

    // Glitch shorter than the debounce window
    btn[0] = 1'b0;
    tick(3);
    btn[0] = 1'b1;
    tick(15);

    // Bounce then settle low
    for (int i = 0; i < 8; i++) begin
      btn[0] = (i % 2 == 1);
      tick(1);
    end
    btn[0] = 1'b0; base = cyc;
    push(base + 6, KPress, 0);
    push(base + 16, KLong, 0);
    tick(20);
    btn[0] = 1'b1; rb = cyc;
    push(rb + 6, KRelease, 0);
    tick(12);

    // Auto-repeat; release seen at edge 29 so the repeat at 28 is still due
    repeat_en[0] = 1'b1;
    btn[0] = 1'b0; base = cyc;
    push(base + 6, KPress, 0);
    push(base + 16, KLong, 0);
    push(base + 19, KRepeat, 0);
    push(base + 22, KRepeat, 0);
    push(base + 25, KRepeat, 0);
    push(base + 28, KRepeat, 0);
    tick(23);
    btn[0] = 1'b1;
    push(base + 29, KRelease, 0);
    tick(15);
    repeat_en[0] = 1'b0;

    // Reset mid-hold while in the long state
    btn[0] = 1'b0; base = cyc;
    push(base + 6, KPress, 0);
    push(base + 16, KLong, 0);
    tick(20);
    #2;
    rst = 1'b1;
    #1;
    check("reset_mid_hold", {22'd0, level, press, rel, lng, rpt}, 32'd0);
    tick(2);
    rst = 1'b0; base = cyc;
    push(base + 6, KPress, 0);
    tick(8);
    btn[0] = 1'b1; rb = cyc;
    push(rb + 6, KRelease, 0);
    tick(12);

    // Independence; ch1 release coincides with its due long and wins
    btn = 2'b00; base = cyc;
    push(base + 6, KPress, 0);
    push(base + 6, KPress, 1);
    push(base + 16, KLong, 0);
    tick(10);
    btn[1] = 1'b1;
    push(base + 16, KRelease, 1);
    tick(15);
    btn[0] = 1'b1; rb = cyc;
    push(rb + 6, KRelease, 0);
    tick(12);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
